// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register map and control-bit constants for the LED PWM driver
package led_pwm_pkg;
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_PERIOD = 1;
    localparam int ADDR_MODE   = 2;
    localparam int ADDR_DIRECT = 3;
    localparam int ADDR_FADE   = 4;
    localparam int ADDR_DUTY0  = 5;
    localparam int CTRL_EN_BIT = 0;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel with double-buffered duty, PWM compare and output mux
// Ports: clk, reset (sync, active-high); commit strobe; wr_duty/wdata shadow write;
//        cnt shared period counter; en/mode/direct output select; duty_sh shadow readback;
//        pwm_out registered LED drive.
// Optional: LED_PWM_FADE_EN adds fade/wrap/period_act inputs and the triangle-ramp logic.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
`ifdef LED_PWM_FADE_EN
    input  logic         fade,
    input  logic         wrap,
    input  logic [W-1:0] period_act,
`endif
    input  logic         commit,
    input  logic         wr_duty,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] cnt,
    input  logic         en,
    input  logic         mode,
    input  logic         direct,
    output logic [W-1:0] duty_sh,
    output logic         pwm_out
);
    logic [W-1:0] duty_act;
    logic [W-1:0] duty_sh_nxt;

    // a write coinciding with commit is forwarded straight into the active copy
    assign duty_sh_nxt = wr_duty ? wdata : duty_sh;

`ifdef LED_PWM_FADE_EN
    logic         up;
    logic         up_nxt;
    logic         at_top;
    logic         at_bot;
    logic [W-1:0] fade_nxt;

    // turn around at either end; with period_act 0 and duty 0 the ramp just parks
    always_comb begin
        at_top   = duty_act >= period_act;
        at_bot   = duty_act == '0;
        up_nxt   = up ? !(at_top && !at_bot) : at_bot;
        fade_nxt = up_nxt ? (at_top ? duty_act : duty_act + W'(1))
                          : (at_bot ? duty_act : duty_act - W'(1));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm_out  <= 1'b0;
`ifdef LED_PWM_FADE_EN
            up       <= 1'b1;
`endif
        end else begin
            duty_sh <= duty_sh_nxt;
            pwm_out <= en & (mode ? (cnt < duty_act) : direct);
`ifdef LED_PWM_FADE_EN
            if (fade && wrap) begin
                duty_act <= fade_nxt;
                up       <= up_nxt;
            end else if (commit && !fade) begin
                duty_act <= duty_sh_nxt;
            end
`else
            if (commit)
                duty_act <= duty_sh_nxt;
`endif
        end
    end
endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: Avalon-MM programmable N-channel LED driver with shared PWM period counter
// Ports: clk, reset (sync, active-high); address/write/writedata/read/readdata register
//        bus (1-cycle read latency); pwm_out per-channel LED drive; period_tick wrap pulse.
// Optional: define LED_PWM_FADE_EN to implement the FADE register and per-channel ramping.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int N            = 8,
    parameter int W            = 8,
    parameter int RESET_PERIOD = 2**W - 1,
    parameter int ADDR_W       = $clog2(5 + N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [N-1:0]      pwm_out,
    output logic              period_tick
);
    logic         en;
    logic [W-1:0] period_sh;
    logic [W-1:0] period_act;
    logic [W-1:0] cnt;
    logic [N-1:0] mode;
    logic [N-1:0] direct;
    logic         wrap;
    logic         commit;
    logic         wr_period;
    logic [W-1:0] wdata;
    logic [N-1:0] wr_duty;
    logic [W-1:0] duty_sh [N];
    logic [31:0]  rd_mux;
    logic         unused_wdata;
`ifdef LED_PWM_FADE_EN
    logic [N-1:0] fade;
`endif

    assign unused_wdata = ^writedata;
    assign wdata        = writedata[W-1:0];
    assign wr_period    = write && address == ADDR_W'(ADDR_PERIOD);
    assign wrap         = en && cnt == period_act;
    // while disabled the active copies track the shadows every cycle
    assign commit       = !en || wrap;

    always_comb begin
        rd_mux = '0;
        if (address == ADDR_W'(ADDR_CTRL))   rd_mux[CTRL_EN_BIT] = en;
        if (address == ADDR_W'(ADDR_PERIOD)) rd_mux[W-1:0] = period_sh;
        if (address == ADDR_W'(ADDR_MODE))   rd_mux[N-1:0] = mode;
        if (address == ADDR_W'(ADDR_DIRECT)) rd_mux[N-1:0] = direct;
`ifdef LED_PWM_FADE_EN
        if (address == ADDR_W'(ADDR_FADE))   rd_mux[N-1:0] = fade;
`endif
        for (int i = 0; i < N; i++)
            if (address == ADDR_W'(ADDR_DUTY0 + i)) rd_mux[W-1:0] = duty_sh[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            period_sh   <= W'(RESET_PERIOD);
            period_act  <= W'(RESET_PERIOD);
            mode        <= '0;
            direct      <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
            readdata    <= '0;
`ifdef LED_PWM_FADE_EN
            fade        <= '0;
`endif
        end else begin
            if (write && address == ADDR_W'(ADDR_CTRL))   en <= writedata[CTRL_EN_BIT];
            if (wr_period)                                period_sh <= wdata;
            if (write && address == ADDR_W'(ADDR_MODE))   mode <= writedata[N-1:0];
            if (write && address == ADDR_W'(ADDR_DIRECT)) direct <= writedata[N-1:0];
`ifdef LED_PWM_FADE_EN
            if (write && address == ADDR_W'(ADDR_FADE))   fade <= writedata[N-1:0];
`endif
            if (commit)
                period_act <= wr_period ? wdata : period_sh;
            cnt         <= commit ? '0 : cnt + W'(1);
            period_tick <= wrap;
            if (read)
                readdata <= rd_mux;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign wr_duty[g] = write && address == ADDR_W'(ADDR_DUTY0 + g);
        led_pwm_channel #(.W(W)) u_ch (
            .clk     (clk),
            .reset   (reset),
`ifdef LED_PWM_FADE_EN
            .fade      (fade[g]),
            .wrap      (wrap),
            .period_act(period_act),
`endif
            .commit  (commit),
            .wr_duty (wr_duty[g]),
            .wdata   (wdata),
            .cnt     (cnt),
            .en      (en),
            .mode    (mode[g]),
            .direct  (direct[g]),
            .duty_sh (duty_sh[g]),
            .pwm_out (pwm_out[g])
        );
    end
endmodule
